// File: rtl/logica_pipeline.sv
// Two-stage registered logic block: x = a, y = ~a or -a, z = selectable bitwise f(b, c).
// The input and output sides use valid/ready handshakes, and a wrapping counter tracks completed output handshakes.
module logica_pipeline #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             y_mode,
    input  logic [1:0]       z_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] z,
    output logic             z_zero,
    input  logic             clear_count,
    output logic [CNT_W-1:0] txn_count
);

    function automatic logic [WIDTH-1:0] calc_y(input logic [WIDTH-1:0] av, input logic mode);
        logic [WIDTH-1:0] r;
        if (mode) begin
            r = ~av + WIDTH'(1'b1);
        end else begin
            r = ~av;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] calc_z(input logic [WIDTH-1:0] bv, input logic [WIDTH-1:0] cv,
                                                input logic [1:0] op);
        logic [WIDTH-1:0] r;
        case (op)
            2'b00:   r = bv & cv;
            2'b01:   r = bv | cv;
            2'b10:   r = bv ^ cv;
            2'b11:   r = ~(bv & cv);
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [WIDTH-1:0] s1_c_r;
    logic             s1_y_mode_r;
    logic [1:0]       s1_z_op_r;

    logic             s2_valid_r;
    logic [WIDTH-1:0] x_r;
    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] z_r;
    logic             z_zero_r;
    logic [CNT_W-1:0] cnt_r;

    logic             adv_s;
    logic             accept_s;
    logic [WIDTH-1:0] y_next_s;
    logic [WIDTH-1:0] z_next_s;
    logic             z_zero_next_s;

    // Handshake control and stage-2 result computation from the stage-1 registers
    always_comb begin
        adv_s         = 1'b0;
        accept_s      = 1'b0;
        y_next_s      = {WIDTH{1'b0}};
        z_next_s      = {WIDTH{1'b0}};
        z_zero_next_s = 1'b0;
        adv_s         = !s2_valid_r || out_ready;
        accept_s      = in_valid && (!s1_valid_r || adv_s);
        y_next_s      = calc_y(s1_a_r, s1_y_mode_r);
        z_next_s      = calc_z(s1_b_r, s1_c_r, s1_z_op_r);
        if (z_next_s == {WIDTH{1'b0}}) begin
            z_zero_next_s = 1'b1;
        end else begin
            z_zero_next_s = 1'b0;
        end
    end

    // Stage 1: capture operands and per-beat modes on an input handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_a_r      <= {WIDTH{1'b0}};
            s1_b_r      <= {WIDTH{1'b0}};
            s1_c_r      <= {WIDTH{1'b0}};
            s1_y_mode_r <= 1'b0;
            s1_z_op_r   <= 2'b00;
        end else if (accept_s) begin
            s1_valid_r  <= 1'b1;
            s1_a_r      <= a;
            s1_b_r      <= b;
            s1_c_r      <= c;
            s1_y_mode_r <= y_mode;
            s1_z_op_r   <= z_op;
        end else if (adv_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2: register results; a stalled beat keeps its values until it is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            x_r        <= {WIDTH{1'b0}};
            y_r        <= {WIDTH{1'b0}};
            z_r        <= {WIDTH{1'b0}};
            z_zero_r   <= 1'b0;
        end else if (adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                x_r      <= s1_a_r;
                y_r      <= y_next_s;
                z_r      <= z_next_s;
                z_zero_r <= z_zero_next_s;
            end else begin
                x_r      <= x_r;
                y_r      <= y_r;
                z_r      <= z_r;
                z_zero_r <= z_zero_r;
            end
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Completed-handshake counter; a clear wins over a same-cycle handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clear_count) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (s2_valid_r && out_ready) begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign in_ready  = !s1_valid_r || adv_s;
    assign out_valid = s2_valid_r;
    assign x         = x_r;
    assign y         = y_r;
    assign z         = z_r;
    assign z_zero    = z_zero_r;
    assign txn_count = cnt_r;

endmodule

// File: tb/tb_logica_pipeline.sv
// Directed bench for logica_pipeline (WIDTH=8, CNT_W=4): vector table plus
// stream, backpressure, counter and mid-stream reset sequences.
module tb_logica_pipeline;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00, b = 8'h00, c = 8'h00;
    logic       y_mode = 1'b0;
    logic [1:0] z_op = 2'b00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] x, y, z;
    logic       z_zero;
    logic       clear_count = 1'b0;
    logic [3:0] txn_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] out_x[$];
    logic [7:0] out_z[$];
    int         out_cyc[$];
    int         acc_cyc[$];

    logica_pipeline #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .y_mode(y_mode), .z_op(z_op),
        .out_valid(out_valid), .out_ready(out_ready),
        .x(x), .y(y), .z(z), .z_zero(z_zero),
        .clear_count(clear_count), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b, c;
        logic       ym;
        logic [1:0] op;
        logic [7:0] ex, ey, ez;
        logic       ezz;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Stream nbeats beats (a=i+1, b=i, c=C3, XOR) with out_ready high for ncyc cycles
    task automatic run_stream(input int nbeats, input int ncyc);
        int sent;
        bit acc;
        sent = 0;
        out_x.delete(); out_z.delete(); out_cyc.delete(); acc_cyc.delete();
        out_ready = 1'b1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            in_valid = (sent < nbeats);
            a = 8'(sent + 1); b = 8'(sent); c = 8'hC3; y_mode = 1'b0; z_op = 2'b10;
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) acc_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                out_x.push_back(x); out_z.push_back(z); out_cyc.push_back(cyc);
            end
            next_cycle();
            if (acc) sent++;
        end
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear_count = 1'b1;
        next_cycle();
        clear_count = 1'b0;
    endtask

    initial begin
        vecs[0] = '{8'h05, 8'hF0, 8'h3C, 1'b0, 2'b00, 8'h05, 8'hFA, 8'h30, 1'b0};
        vecs[1] = '{8'h05, 8'hF0, 8'h3C, 1'b1, 2'b01, 8'h05, 8'hFB, 8'hFC, 1'b0};
        vecs[2] = '{8'h05, 8'hF0, 8'h3C, 1'b0, 2'b10, 8'h05, 8'hFA, 8'hCC, 1'b0};
        vecs[3] = '{8'h05, 8'hF0, 8'h3C, 1'b1, 2'b11, 8'h05, 8'hFB, 8'hCF, 1'b0};
        vecs[4] = '{8'h80, 8'hAA, 8'hAA, 1'b1, 2'b10, 8'h80, 8'h80, 8'h00, 1'b1};
        vecs[5] = '{8'h00, 8'h00, 8'hFF, 1'b1, 2'b00, 8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{8'hFF, 8'h0F, 8'hF0, 1'b0, 2'b11, 8'hFF, 8'h00, 8'hFF, 1'b0};
        vecs[7] = '{8'h01, 8'h00, 8'h00, 1'b1, 2'b01, 8'h01, 8'hFF, 8'h00, 1'b1};

        // Reset with random inputs
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            y_mode = 1'($urandom); z_op = 2'($urandom);
            @(negedge clk);
        end
        check("rst out_valid", out_valid, 0);
        check("rst x", x, 0);
        check("rst y", y, 0);
        check("rst z", z, 0);
        check("rst z_zero", z_zero, 0);
        check("rst txn_count", txn_count, 0);
        check("rst in_ready", in_ready, 1);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Table vectors, one beat at a time
        for (int i = 0; i < 8; i++) begin
            a = vecs[i].a; b = vecs[i].b; c = vecs[i].c;
            y_mode = vecs[i].ym; z_op = vecs[i].op; in_valid = 1'b1;
            next_cycle();
            in_valid = 1'b0;
            y_mode = ~vecs[i].ym; z_op = ~vecs[i].op;
            next_cycle();
            check($sformatf("vec%0d out_valid", i), out_valid, 1);
            check($sformatf("vec%0d x", i), x, vecs[i].ex);
            check($sformatf("vec%0d y", i), y, vecs[i].ey);
            check($sformatf("vec%0d z", i), z, vecs[i].ez);
            check($sformatf("vec%0d z_zero", i), z_zero, vecs[i].ezz);
            next_cycle();
        end
        check("vec txn_count", txn_count, 8);

        // Throughput: 8 back-to-back beats
        do_clear();
        check("clear txn_count", txn_count, 0);
        run_stream(8, 14);
        check("tp out count", out_x.size(), 8);
        if (out_x.size() == 8 && acc_cyc.size() == 8) begin
            check("tp latency", out_cyc[0], acc_cyc[0] + 2);
            check("tp accept contiguous", acc_cyc[7], acc_cyc[0] + 7);
            check("tp output contiguous", out_cyc[7], out_cyc[0] + 7);
            for (int i = 0; i < 8; i++) begin
                check($sformatf("tp x%0d", i), out_x[i], 8'(i + 1));
                check($sformatf("tp z%0d", i), out_z[i], 8'(i) ^ 8'hC3);
            end
        end
        check("tp txn_count", txn_count, 8);

        // Backpressure: out_ready low for 5 cycles while 4 beats are offered
        begin
            logic [7:0] pend[$];
            int nacc;
            bit acc;
            pend = '{8'h11, 8'h22, 8'h33, 8'h44};
            nacc = 0;
            do_clear();
            out_x.delete();
            for (int cyc = 0; cyc < 20; cyc++) begin
                out_ready = (cyc >= 5);
                in_valid = (pend.size() > 0);
                if (pend.size() > 0) a = pend[0];
                b = 8'h0F; c = 8'h0F; y_mode = 1'b0; z_op = 2'b00;
                @(negedge clk);
                acc = in_valid && in_ready;
                if (out_valid && out_ready) out_x.push_back(x);
                if (cyc >= 2 && cyc <= 4) begin
                    check($sformatf("bp in_ready c%0d", cyc), in_ready, 0);
                    check($sformatf("bp out_valid c%0d", cyc), out_valid, 1);
                    check($sformatf("bp x held c%0d", cyc), x, 8'h11);
                    check($sformatf("bp y held c%0d", cyc), y, 8'hEE);
                end
                if (cyc == 4) check("bp accepted", nacc + (acc ? 1 : 0), 2);
                next_cycle();
                if (acc) begin
                    void'(pend.pop_front());
                    nacc++;
                end
            end
            in_valid = 1'b0;
            check("bp delivered", out_x.size(), 4);
            if (out_x.size() == 4) begin
                check("bp order0", out_x[0], 8'h11);
                check("bp order1", out_x[1], 8'h22);
                check("bp order2", out_x[2], 8'h33);
                check("bp order3", out_x[3], 8'h44);
            end
            check("bp txn_count", txn_count, 4);
        end

        // Counter wrap with CNT_W=4, then clear against a concurrent handshake
        do_clear();
        run_stream(17, 24);
        check("wrap handshakes", out_x.size(), 17);
        check("wrap txn_count", txn_count, 1);
        a = 8'h77; in_valid = 1'b1; out_ready = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        check("clr hs out_valid", out_valid, 1);
        clear_count = 1'b1;
        next_cycle();
        clear_count = 1'b0;
        check("clr hs txn_count", txn_count, 0);
        check("clr hs drained", out_valid, 0);

        // Reset mid-stream with two beats in flight
        out_ready = 1'b0;
        a = 8'hA1; in_valid = 1'b1;
        next_cycle();
        a = 8'hA2;
        next_cycle();
        in_valid = 1'b0;
        check("mid pre out_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid rst out_valid", out_valid, 0);
        check("mid rst x", x, 0);
        check("mid rst y", y, 0);
        check("mid rst z", z, 0);
        check("mid rst in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
        out_ready = 1'b1;
        a = 8'h5A; b = 8'h00; c = 8'h00; y_mode = 1'b1; z_op = 2'b00; in_valid = 1'b1;
        next_cycle();
        in_valid = 1'b0;
        check("mid new not early", out_valid, 0);
        next_cycle();
        check("mid new out_valid", out_valid, 1);
        check("mid new x", x, 8'h5A);
        check("mid new y", y, 8'hA6);
        next_cycle();
        check("mid no stale", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
